mem_arbiter: RTL

Two-requester arbiter for the single 32×16 data-memory port of the processor. It lets two masters share one memory port, for example a second pipeline/ALU core or a DMA/loader. Each master runs a req/ack handshake, and the arbiter sequences one access at a time through a three-state FSM. It sits between the masters' memory-side ports (`address`, `readwriteN`, `data_out`, `data_in`) and the memory itself.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_LOCK_EN to let the previous owner keep the port with lock<n> for read-modify-write.
module mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              lock0,
   input  logic              lock1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_readwriteN,
   output logic [DATA_W-1:0] mem_data_out,
   input  logic [DATA_W-1:0] mem_data_in
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;
   logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
   logic                mem_readwriten_q, mem_readwriten_d;
   logic [DATA_W-1:0]   mem_data_out_q, mem_data_out_d;

   logic                any_req;
   logic                winner;

   // Round-robin: on a tie the master that did not win last time goes next.
   always_comb begin
      any_req = req0 | req1;
      winner  = 1'b0;
      if (req0 && req1) begin
         winner = ~last_q;
      end else if (req1) begin
         winner = 1'b1;
      end
`ifdef MEM_ARB_LOCK_EN
      if (last_q ? (lock1 && req1) : (lock0 && req0)) begin
         winner = last_q;
      end
`endif
   end

`ifndef MEM_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = lock0 | lock1;
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d          = state_q;
      owner_d          = owner_q;
      last_d           = last_q;
      ack0_d           = 1'b0;
      ack1_d           = 1'b0;
      rdata0_d         = rdata0_q;
      rdata1_d         = rdata1_q;
      mem_address_d    = mem_address_q;
      mem_readwriten_d = mem_readwriten_q;
      mem_data_out_d   = mem_data_out_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d          = ST_ACCESS;
               owner_d          = winner;
               last_d           = winner;
               mem_address_d    = winner ? addr1  : addr0;
               mem_readwriten_d = winner ? rw1    : rw0;
               mem_data_out_d   = winner ? wdata1 : wdata0;
            end
         end
         ST_ACCESS: begin
            // The write strobe ends here, so it lasts exactly the ACCESS cycle.
            state_d          = ST_RESP;
            mem_readwriten_d = 1'b1;
            if (mem_readwriten_q) begin
               if (owner_q) rdata1_d = mem_data_in;
               else         rdata0_d = mem_data_in;
            end
            if (owner_q) ack1_d = 1'b1;
            else         ack0_d = 1'b1;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d          = ST_IDLE;
            mem_readwriten_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         owner_q          <= 1'b0;
         last_q           <= 1'b1;
         ack0_q           <= 1'b0;
         ack1_q           <= 1'b0;
         rdata0_q         <= '0;
         rdata1_q         <= '0;
         mem_address_q    <= '0;
         mem_readwriten_q <= 1'b1;
         mem_data_out_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         state_q          <= state_d;
         owner_q          <= owner_d;
         last_q           <= last_d;
         ack0_q           <= ack0_d;
         ack1_q           <= ack1_d;
         rdata0_q         <= rdata0_d;
         rdata1_q         <= rdata1_d;
         mem_address_q    <= mem_address_d;
         mem_readwriten_q <= mem_readwriten_d;
         mem_data_out_q   <= mem_data_out_d;
      end
   end

   assign ack0           = ack0_q;
   assign ack1           = ack1_q;
   assign rdata0         = rdata0_q;
   assign rdata1         = rdata1_q;
   assign mem_address    = mem_address_q;
   assign mem_readwriteN = mem_readwriten_q;
   assign mem_data_out   = mem_data_out_q;

   a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(ack0_q && ack1_q));
   a_write_only_in_access: assert property (@(posedge clk) disable iff (!rst_n)
      !mem_readwriten_q |-> (state_q == ST_ACCESS));

endmodule
